// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the handshaked sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLT  = 3'b101,
        OP_MUL  = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU unit: result, carry/not-borrow and signed overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_t              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
    output logic             cout_o,
    output logic             ovf_o
);

    logic [WIDTH:0] add_s;
    logic [WIDTH:0] sub_s;

    assign add_s = {1'b0, a_i} + {1'b0, b_i};
    // Carry out of a + ~b + 1 is the unsigned "a >= b" flag.
    assign sub_s = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        y_o    = '0;
        cout_o = 1'b0;
        ovf_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                y_o    = add_s[WIDTH-1:0];
                cout_o = add_s[WIDTH];
                ovf_o  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                y_o    = sub_s[WIDTH-1:0];
                cout_o = sub_s[WIDTH];
                ovf_o  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_s[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLT:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registered single-cycle ops plus a WIDTH-step shift-add unsigned multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_hi,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             err
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q, acc_q, mplr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] o_q, o_hi_q;
    logic             cout_q, ovf_q, zero_q, err_q;

    op_t              op_in;
    logic             accept;
    logic [WIDTH-1:0] core_y;
    logic             core_cout, core_ovf;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] acc_d, mplr_d;

    assign op_in     = op_t'(op);
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);

    assign o    = o_q;
    assign o_hi = o_hi_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
    assign err  = err_q;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i   (op_in),
        .a_i    (i0),
        .b_i    (i1),
        .y_o    (core_y),
        .cout_o (core_cout),
        .ovf_o  (core_ovf)
    );

    // One shift-add step: the carry of the partial add shifts into the accumulator MSB.
    assign step_sum = {1'b0, acc_q} + {1'b0, (mplr_q[0] ? mcand_q : {WIDTH{1'b0}})};
    assign acc_d    = step_sum[WIDTH:1];
    assign mplr_d   = {step_sum[0], mplr_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            o_q     <= '0;
            o_hi_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (op_in == OP_MUL) begin
                            state_q <= S_MUL;
                            mcand_q <= i0;
                            mplr_q  <= i1;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= S_DONE;
                            o_q     <= core_y;
                            o_hi_q  <= '0;
                            cout_q  <= core_cout;
                            ovf_q   <= core_ovf;
                            zero_q  <= (core_y == '0);
                            err_q   <= (op_in == OP_RSVD);
                        end
                    end else if (state_q == S_DONE && out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                        o_q     <= mplr_d;
                        o_hi_q  <= acc_d;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        zero_q  <= ({acc_d, mplr_d} == '0);
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq with a queue-based scoreboard and an independent output monitor.
module tb_alu_seq;

    typedef struct packed {
        logic [15:0] o;
        logic [15:0] o_hi;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [15:0] i0 = '0, i1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] o, o_hi;
    logic        cout, ovf, zero, err;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   cyc      = 0;
    int   pop_cnt  = 0;
    int   pop_cyc[64];

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .i0        (i0),
        .i1        (i1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .o_hi      (o_hi),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(o), 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 64'({o, o_hi, cout, ovf, zero, err}), 64'(e));
            end
            if (pop_cnt < 64) pop_cyc[pop_cnt] = cyc;
            pop_cnt++;
        end
    end

    function automatic exp_t mk(input logic [15:0] eo, input logic [15:0] ehi,
                                input logic c, input logic v, input logic z, input logic e);
        exp_t r;
        r = '{o: eo, o_hi: ehi, cout: c, ovf: v, zero: z, err: e};
        return r;
    endfunction

    // Presents an op, waits (bounded) for acceptance, returns 1 time unit after the accepting edge.
    task automatic send(input logic [2:0] op_v, input logic [15:0] a, input logic [15:0] b,
                        input exp_t e, input bit push);
        int n;
        in_valid = 1'b1;
        op = op_v;
        i0 = a;
        i1 = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        if (push) exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        i0 = 16'hDEAD;
        i1 = 16'hBEEF;
        op = 3'b010;
    endtask

    initial begin
        bit bad;
        bit ok;
        int base;
        logic [15:0] xa[8] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555, 16'h1234, 16'h8000, 16'h0F0F, 16'hFFFF};
        logic [15:0] xb[8] = '{16'h0000, 16'h0000, 16'h5555, 16'h5555, 16'h4321, 16'h0001, 16'hF0F0, 16'hFFFF};
        logic [15:0] xr[8] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h5115, 16'h8001, 16'hFFFF, 16'h0000};

        #3;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", 64'({out_valid, o, o_hi, cout, ovf, zero, err}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        send(3'b000, 16'hFFFF, 16'h0001, mk(16'h0000, 16'h0000, 1, 0, 1, 0), 1);
        check("add_lat1", 64'(out_valid), 64'd1);
        send(3'b001, 16'h8000, 16'h0001, mk(16'h7FFF, 16'h0000, 1, 1, 0, 0), 1);
        send(3'b101, 16'hFFFF, 16'h0001, mk(16'h0001, 16'h0000, 0, 0, 0, 0), 1);

        // MUL latency: done after 16 further edges, in_ready low meanwhile.
        send(3'b110, 16'h1234, 16'h5678, mk(16'h0060, 16'h0626, 0, 0, 0, 0), 1);
        check("mul_busy0", 64'({out_valid, in_ready}), 64'd0);
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || in_ready) bad = 1;
        end
        check("mul_busy", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        check("mul_lat", 64'(out_valid), 64'd1);
        send(3'b110, 16'hFFFF, 16'hFFFF, mk(16'h0001, 16'hFFFE, 0, 0, 0, 0), 1);
        repeat (17) @(posedge clk);
        #1;

        // Back-pressure: result held, nothing accepted, then simultaneous take + accept.
        out_ready = 1'b0;
        send(3'b010, 16'hF0F0, 16'h0FF0, mk(16'h00F0, 16'h0000, 0, 0, 0, 0), 1);
        in_valid = 1'b1;
        op = 3'b011;
        i0 = 16'h1200;
        i1 = 16'h0034;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold", 64'({out_valid, o, zero}), 64'({1'b1, 16'h00F0, 1'b0}));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            i1 = 16'h0034 ^ 16'(k);
        end
        out_ready = 1'b1;
        send(3'b011, 16'h1200, 16'h0034, mk(16'h1234, 16'h0000, 0, 0, 0, 0), 1);
        check("bp_b2b_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Streaming XOR, one result per cycle.
        base = pop_cnt;
        for (int k = 0; k < 8; k++)
            send(3'b100, xa[k], xb[k], mk(xr[k], 16'h0000, 0, 0, (xr[k] == 16'h0000), 0), 1);
        @(posedge clk);
        #1;
        ok = (pop_cnt == base + 8);
        for (int k = base + 1; k < base + 8 && k < 64; k++)
            if (pop_cyc[k] != pop_cyc[k-1] + 1) ok = 0;
        check("stream_consec", 64'(ok), 64'd1);

        // Reset mid-multiply: no result may ever come out of it.
        send(3'b110, 16'h00FF, 16'h00FF, mk(16'h0000, 16'h0000, 0, 0, 0, 0), 0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mul_ready", 64'(in_ready), 64'd1);
        check("rst_mul_outputs", 64'({out_valid, o, o_hi, cout, ovf, zero, err}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(3'b000, 16'h0002, 16'h0003, mk(16'h0005, 16'h0000, 0, 0, 0, 0), 1);
        send(3'b111, 16'h1234, 16'h5678, mk(16'h0000, 16'h0000, 0, 0, 1, 1), 1);
        repeat (20) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
